// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS time-keeping controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    localparam int HOURS_W   = 5;
    localparam int MIN_SEC_W = 6;

    localparam logic [HOURS_W-1:0]   MAX_HOURS   = 5'd23;
    localparam logic [MIN_SEC_W-1:0] MAX_MIN_SEC = 6'd59;

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Button step generator: one pulse on a rising edge, then auto-repeat
// while the key is held alone (the other button released).
module btn_repeat #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk_100MHz_i,
    input  logic rstn_i,
    input  logic key_i,
    input  logic inhibit_i,
    output logic step_o
);

    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    // After a repeat the counter restarts so the next hit lands
    // exactly REPEAT_PERIOD cycles later.
    localparam logic [CNT_W-1:0] DELAY_VAL  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic             key_prev_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             key_edge;
    logic             repeat_hit;

    // Edge detection and hold counter; the step is combinational so the
    // owner registers its effect one cycle after the key is first seen high.
    always_comb begin
        key_edge   = key_i & ~key_prev_reg;
        repeat_hit = 1'b0;
        cnt_next   = '0;
        if (key_i && !inhibit_i) begin
            if (cnt_reg == DELAY_VAL) begin
                repeat_hit = 1'b1;
                cnt_next   = RELOAD_VAL;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
        step_o = key_edge | repeat_hit;
    end

    // History resets high so a key held through reset yields no edge.
    always_ff @(posedge clk_100MHz_i) begin
        if (!rstn_i) begin
            key_prev_reg <= 1'b1;
            cnt_reg      <= '0;
        end else begin
            key_prev_reg <= key_i;
            cnt_reg      <= cnt_next;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-keeping and time-setting controller: owns HH:MM:SS, advances on the
// 1 Hz tick in RUN, edits one field at a time in the SET modes and drives
// the blink mask for the field under edit.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int BLINK_HALF    = 25_000_000
) (
    input  logic                 clk_100MHz_i,
    input  logic                 rstn_i,
    input  logic                 seconds_pulse_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    input  logic                 config_i,
    output logic [MIN_SEC_W-1:0] seconds_o,
    output logic [MIN_SEC_W-1:0] minutes_o,
    output logic [HOURS_W-1:0]   hours_o,
    output logic [1:0]           mode_o,
    output logic [2:0]           blank_mask_o
);

    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    mode_t                mode_reg, mode_next;
    logic [HOURS_W-1:0]   hours_reg, hours_next;
    logic [MIN_SEC_W-1:0] minutes_reg, minutes_next;
    logic [MIN_SEC_W-1:0] seconds_reg, seconds_next;
    logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
    logic                 phase_reg, phase_next;
    logic [2:0]           mask_reg, mask_next;
    logic                 cfg_prev_reg;

    logic [1:0] key_lvl;
    logic [1:0] key_step;
    logic       cfg_edge;
    logic       do_inc;
    logic       do_dec;
    logic       step;

    // Index 0 = inc, 1 = dec; each button is inhibited by the other.
    assign key_lvl = {dec_i, inc_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_repeat #(
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD)
            ) u_btn (
                .clk_100MHz_i(clk_100MHz_i),
                .rstn_i      (rstn_i),
                .key_i       (key_lvl[gi]),
                .inhibit_i   (key_lvl[1-gi]),
                .step_o      (key_step[gi])
            );
        end
    endgenerate

    // Next-state logic: mode sequencing, time update, blink and mask.
    always_comb begin
        mode_next      = mode_reg;
        hours_next     = hours_reg;
        minutes_next   = minutes_reg;
        seconds_next   = seconds_reg;
        blink_cnt_next = blink_cnt_reg;
        phase_next     = phase_reg;
        mask_next      = 3'b000;

        cfg_edge = config_i & ~cfg_prev_reg;
        // Opposing steps in the same cycle cancel; a config edge wins over a step.
        do_inc = key_step[0] & ~key_step[1];
        do_dec = key_step[1] & ~key_step[0];
        step   = (do_inc | do_dec) & ~cfg_edge & (mode_reg != RUN);

        case (mode_reg)
            RUN: begin
                if (seconds_pulse_i) begin
                    if (seconds_reg == MAX_MIN_SEC) begin
                        seconds_next = '0;
                        if (minutes_reg == MAX_MIN_SEC) begin
                            minutes_next = '0;
                            hours_next   = (hours_reg == MAX_HOURS) ? '0 : hours_reg + 1'b1;
                        end else begin
                            minutes_next = minutes_reg + 1'b1;
                        end
                    end else begin
                        seconds_next = seconds_reg + 1'b1;
                    end
                end
            end
            SET_H: begin
                if (step) begin
                    if (do_inc) hours_next = (hours_reg == MAX_HOURS) ? '0 : hours_reg + 1'b1;
                    else        hours_next = (hours_reg == '0) ? MAX_HOURS : hours_reg - 1'b1;
                end
            end
            SET_M: begin
                if (step) begin
                    if (do_inc) minutes_next = (minutes_reg == MAX_MIN_SEC) ? '0 : minutes_reg + 1'b1;
                    else        minutes_next = (minutes_reg == '0) ? MAX_MIN_SEC : minutes_reg - 1'b1;
                end
            end
            default: begin
                if (step) begin
                    if (do_inc) seconds_next = (seconds_reg == MAX_MIN_SEC) ? '0 : seconds_reg + 1'b1;
                    else        seconds_next = (seconds_reg == '0) ? MAX_MIN_SEC : seconds_reg - 1'b1;
                end
            end
        endcase

        if (cfg_edge) begin
            case (mode_reg)
                RUN:     mode_next = SET_H;
                SET_H:   mode_next = SET_M;
                SET_M:   mode_next = SET_S;
                default: mode_next = RUN;
            endcase
        end

        // Any edit activity restarts the blink so the field is shown at once.
        if (cfg_edge || step) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
        end

        case (mode_next)
            SET_H:   mask_next = {phase_next, 2'b00};
            SET_M:   mask_next = {1'b0, phase_next, 1'b0};
            SET_S:   mask_next = {2'b00, phase_next};
            default: mask_next = 3'b000;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_100MHz_i) begin
        if (!rstn_i) begin
            mode_reg      <= RUN;
            hours_reg     <= '0;
            minutes_reg   <= '0;
            seconds_reg   <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            mask_reg      <= 3'b000;
            cfg_prev_reg  <= 1'b1;
        end else begin
            mode_reg      <= mode_next;
            hours_reg     <= hours_next;
            minutes_reg   <= minutes_next;
            seconds_reg   <= seconds_next;
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            mask_reg      <= mask_next;
            cfg_prev_reg  <= config_i;
        end
    end

    assign seconds_o    = seconds_reg;
    assign minutes_o    = minutes_reg;
    assign hours_o      = hours_reg;
    assign mode_o       = mode_reg;
    assign blank_mask_o = mask_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with short repeat/blink timing.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    logic       clk;
    logic       rstn;
    logic       pulse;
    logic       inc;
    logic       dec;
    logic       cfg;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [1:0] mode;
    logic [2:0] mask;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       inc;
        logic       dec;
        logic       cfg;
        logic       pulse;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] mode;
        logic [2:0] mask;
    } vec_t;

    vec_t vecs[14];

    clock_set_ctrl #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .BLINK_HALF   (5)
    ) dut (
        .clk_100MHz_i   (clk),
        .rstn_i         (rstn),
        .seconds_pulse_i(pulse),
        .inc_i          (inc),
        .dec_i          (dec),
        .config_i       (cfg),
        .seconds_o      (seconds),
        .minutes_o      (minutes),
        .hours_o        (hours),
        .mode_o         (mode),
        .blank_mask_o   (mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply input levels for one cycle, then settle just after the edge.
    task automatic cyc(input logic i, input logic d, input logic c, input logic p);
        inc   = i;
        dec   = d;
        cfg   = c;
        pulse = p;
        @(posedge clk);
        #1;
    endtask

    // which: 0 = inc, 1 = dec, 2 = config; each press is one high and one low cycle.
    task automatic press(input int which, input int n);
        for (int k = 0; k < n; k++) begin
            cyc(which == 0, which == 1, which == 2, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check(input string name, input logic [4:0] h, input logic [5:0] m,
                         input logic [5:0] s, input logic [1:0] md, input logic [2:0] mk);
        checks++;
        if (hours !== h || minutes !== m || seconds !== s || mode !== md || mask !== mk) begin
            errors++;
            $display("FAIL %s: got %0d:%0d:%0d mode=%0d mask=%b, expected %0d:%0d:%0d mode=%0d mask=%b",
                     name, hours, minutes, seconds, mode, mask, h, m, s, md, mk);
        end else begin
            $display("ok   %s: %0d:%0d:%0d mode=%0d mask=%b", name, hours, minutes, seconds, mode, mask);
        end
    endtask

    initial begin
        // Table for config/blink/dec-wrap sequencing, starting from RUN 00:00:00.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  6'd0, 6'd1, SET_H, 3'b000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  6'd0, 6'd1, SET_H, 3'b000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  6'd0, 6'd1, SET_H, 3'b000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  6'd0, 6'd1, SET_H, 3'b000};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  6'd0, 6'd1, SET_H, 3'b000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  6'd0, 6'd1, SET_H, 3'b100};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd23, 6'd0, 6'd1, SET_H, 3'b000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd23, 6'd0, 6'd1, SET_H, 3'b000};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd23, 6'd0, 6'd1, SET_M, 3'b000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd23, 6'd0, 6'd1, SET_M, 3'b000};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd23, 6'd0, 6'd1, SET_S, 3'b000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd23, 6'd0, 6'd1, SET_S, 3'b000};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd23, 6'd0, 6'd1, RUN,   3'b000};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd23, 6'd0, 6'd1, RUN,   3'b000};

        rstn  = 1'b0;
        inc   = 1'b0;
        dec   = 1'b0;
        cfg   = 1'b0;
        pulse = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset", 5'd0, 6'd0, 6'd0, RUN, 3'b000);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // 1: free-running count and full rollover.
        for (int i = 0; i < 3661; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 59) check("count_60", 5'd0, 6'd1, 6'd0, RUN, 3'b000);
        end
        check("count_3661", 5'd1, 6'd1, 6'd1, RUN, 3'b000);
        press(2, 1);
        press(1, 2);
        check("preload_h", 5'd23, 6'd1, 6'd1, SET_H, 3'b000);
        press(2, 1);
        press(1, 2);
        press(2, 1);
        press(1, 2);
        press(2, 1);
        check("preload", 5'd23, 6'd59, 6'd59, RUN, 3'b000);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("rollover", 5'd0, 6'd0, 6'd0, RUN, 3'b000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // 2: table-driven mode sequencing and blink.
        for (int v = 0; v < 14; v++) begin
            cyc(vecs[v].inc, vecs[v].dec, vecs[v].cfg, vecs[v].pulse);
            check($sformatf("vec%0d", v), vecs[v].h, vecs[v].m, vecs[v].s, vecs[v].mode, vecs[v].mask);
        end

        // 3: minute wrap without carry, tick ignored while editing.
        press(2, 2);
        press(1, 2);
        check("min_58", 5'd23, 6'd58, 6'd1, SET_M, 3'b000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("min_59", 5'd23, 6'd59, 6'd1, SET_M, 3'b000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("min_wrap", 5'd23, 6'd0, 6'd1, SET_M, 3'b000);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("blink_m_vis", 5'd23, 6'd0, 6'd1, SET_M, 3'b000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("blink_m_blank", 5'd23, 6'd0, 6'd1, SET_M, 3'b010);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("tick_frozen", 5'd23, 6'd0, 6'd1, SET_M, 3'b010);

        // 4: auto-repeat on seconds, then simultaneous inc/dec.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k <= 20; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 0)  check("rep_edge", 5'd23, 6'd0, 6'd2, SET_S, 3'b000);
            if (k == 7)  check("rep_k7",   5'd23, 6'd0, 6'd2, SET_S, 3'b001);
            if (k == 8)  check("rep_k8",   5'd23, 6'd0, 6'd3, SET_S, 3'b000);
            if (k == 20) check("rep_k20",  5'd23, 6'd0, 6'd6, SET_S, 3'b000);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("both_edge", 5'd23, 6'd0, 6'd6, SET_S, 3'b000);
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("both_hold", 5'd23, 6'd0, 6'd6, SET_S, 3'b000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // 5: config edge and inc edge together.
        press(2, 2);
        check("in_set_h", 5'd23, 6'd0, 6'd6, SET_H, 3'b000);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("cfg_beats_step", 5'd23, 6'd0, 6'd6, SET_M, 3'b000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // 6: reach 12:34:56 in SET_M, reset mid-edit, config held through reset.
        press(2, 1);
        press(1, 10);
        press(2, 2);
        press(1, 11);
        press(2, 1);
        press(1, 26);
        check("edit_123456", 5'd12, 6'd34, 6'd56, SET_M, 3'b000);
        rstn = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_mid_edit", 5'd0, 6'd0, 6'd0, RUN, 3'b000);
        rstn = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        rstn = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("cfg_held_reset", 5'd0, 6'd0, 6'd0, RUN, 3'b000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("cfg_after_reset", 5'd0, 6'd0, 6'd0, SET_H, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
